// File: rtl/alu_seq_pkg.sv
// Shared types and flag helper for the ALU command sequencer.
// SEQ_SIGNED_FLAGS_EN selects whether calc_nv results reach status_n/status_v.
package alu_seq_pkg;

  localparam int DATA_W    = 16;
  localparam int NREGS     = 8;
  localparam int REG_SEL_W = $clog2(NREGS);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_NOT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDA,
    S_RDB,
    S_EXEC,
    S_WB
  } seq_state_e;

  // Returns {n, v}; overflow only has meaning for ADD/SUB.
  function automatic logic [1:0] calc_nv(alu_op_e op, logic [DATA_W-1:0] a,
                                         logic [DATA_W-1:0] b, logic [DATA_W-1:0] res);
    logic v;
    case (op)
      OP_ADD:  v = (a[DATA_W-1] == b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
      OP_SUB:  v = (a[DATA_W-1] != b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
      default: v = 1'b0;
    endcase
    return {res[DATA_W-1], v};
  endfunction

endpackage

// File: rtl/bin_shifter.sv
// Single-bit B-operand shifter (none / LSL1 / LSR1 / ASR1), purely combinational.
module bin_shifter
  import alu_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] din,
  input  shift_e       shift,
  output logic [W-1:0] dout
);

  always_comb begin
    dout = din;
    case (shift)
      SH_LSL1: dout = {din[W-2:0], 1'b0};
      SH_LSR1: dout = {1'b0, din[W-1:1]};
      SH_ASR1: dout = {din[W-1], din[W-1:1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Multi-cycle controller sequencing register reads, ALU issue and writeback.
// Build option: SEQ_SIGNED_FLAGS_EN enables status_n/status_v; otherwise they are tied low.
//
// state | meaning
// IDLE  | ready; latch command on cmd_valid
// RDA   | A <= R[rn]
// RDB   | B <= shift(R[rm])
// EXEC  | ALU driven from A/B/op; capture C and flags
// WB    | optional register write, rsp_valid pulse
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_mov,
  input  logic [1:0]               cmd_op,
  input  logic                     cmd_wb,
  input  logic [$clog2(NREGS)-1:0] cmd_rd,
  input  logic [$clog2(NREGS)-1:0] cmd_rn,
  input  logic [$clog2(NREGS)-1:0] cmd_rm,
  input  logic [1:0]               cmd_shift,
  input  logic [DATA_W-1:0]        cmd_imm,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     status_z,
  output logic                     status_n,
  output logic                     status_v,
  output logic [DATA_W-1:0]        alu_ain,
  output logic [DATA_W-1:0]        alu_bin,
  output logic [1:0]               alu_op,
  input  logic [DATA_W-1:0]        alu_out,
  input  logic                     alu_z,
  input  logic [$clog2(NREGS)-1:0] dbg_sel,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int SEL_W = $clog2(NREGS);

  seq_state_e        state, state_nxt;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] a_q, b_q, c_q, imm_q, b_shifted;
  logic              mov_q, wb_q;
  alu_op_e           op_q;
  shift_e            shift_q;
  logic [SEL_W-1:0]  rd_q, rn_q, rm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_nxt = cmd_mov ? S_WB : S_RDA;
      S_RDA:   state_nxt = S_RDB;
      S_RDB:   state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  bin_shifter #(.W(DATA_W)) u_bin_shifter (
    .din   (regs[rm_q]),
    .shift (shift_q),
    .dout  (b_shifted)
  );

  // rsp_data is loaded on entry to WB so it is valid alongside the rsp_valid pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      imm_q    <= '0;
      mov_q    <= 1'b0;
      wb_q     <= 1'b0;
      op_q     <= OP_ADD;
      shift_q  <= SH_NONE;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      rsp_data <= '0;
      status_z <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          mov_q   <= cmd_mov;
          op_q    <= alu_op_e'(cmd_op);
          wb_q    <= cmd_wb;
          rd_q    <= cmd_rd;
          rn_q    <= cmd_rn;
          rm_q    <= cmd_rm;
          shift_q <= shift_e'(cmd_shift);
          imm_q   <= cmd_imm;
          if (cmd_mov) rsp_data <= cmd_imm;
        end
        S_RDA: a_q <= regs[rn_q];
        S_RDB: b_q <= b_shifted;
        S_EXEC: begin
          c_q      <= alu_out;
          rsp_data <= alu_out;
          status_z <= alu_z;
        end
        S_WB: if (mov_q || wb_q) regs[rd_q] <= mov_q ? imm_q : c_q;
        default: ;
      endcase
    end
  end

`ifdef SEQ_SIGNED_FLAGS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_n <= 1'b0;
      status_v <= 1'b0;
    end else if (state == S_EXEC) begin
      {status_n, status_v} <= calc_nv(op_q, a_q, b_q, alu_out);
    end
  end
`else
  assign status_n = 1'b0;
  assign status_v = 1'b0;
`endif

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_WB);
  assign alu_ain   = a_q;
  assign alu_bin   = b_q;
  assign alu_op    = op_q;
  assign dbg_data  = regs[dbg_sel];

  // c_q is the writeback source; rsp_data carries the same value for compares.

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU and command-level model.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_mov, cmd_wb;
  logic [1:0]  cmd_op, cmd_shift;
  logic [2:0]  cmd_rd, cmd_rn, cmd_rm, dbg_sel;
  logic [15:0] cmd_imm, rsp_data, alu_ain, alu_bin, alu_out, dbg_data;
  logic        rsp_valid, status_z, status_n, status_v, alu_z;
  logic [1:0]  alu_op;

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mov(cmd_mov), .cmd_op(cmd_op), .cmd_wb(cmd_wb), .cmd_rd(cmd_rd),
    .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_shift(cmd_shift), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .status_z(status_z),
    .status_n(status_n), .status_v(status_v), .alu_ain(alu_ain), .alu_bin(alu_bin),
    .alu_op(alu_op), .alu_out(alu_out), .alu_z(alu_z), .dbg_sel(dbg_sel),
    .dbg_data(dbg_data)
  );

  // Stand-in for the external 16-bit ALU
  always_comb begin
    case (alu_op)
      2'b00:   alu_out = alu_ain + alu_bin;
      2'b01:   alu_out = alu_ain - alu_bin;
      2'b10:   alu_out = alu_ain & alu_bin;
      default: alu_out = ~alu_bin;
    endcase
  end
  assign alu_z = (alu_out == 16'h0000);

  typedef struct {
    logic        mov;
    logic [1:0]  op;
    logic        wb;
    logic [2:0]  rd, rn, rm;
    logic [1:0]  sh;
    logic [15:0] imm;
  } cmd_t;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [15:0] m_r [8];
  logic        m_z, m_n, m_v;

  function automatic cmd_t mk(logic mov, logic [1:0] op, logic wb, logic [2:0] rd,
                              logic [2:0] rn, logic [2:0] rm, logic [1:0] sh, logic [15:0] imm);
    cmd_t c;
    c.mov = mov; c.op = op; c.wb = wb; c.rd = rd; c.rn = rn; c.rm = rm; c.sh = sh; c.imm = imm;
    return c;
  endfunction

  // Command-level reference: signed arithmetic on ints, flags from the numeric result.
  task automatic model_cmd(input cmd_t c, output logic [15:0] exp_data,
                           output logic [15:0] exp_b, output int exp_lat);
    logic [15:0] a, b, res;
    int sa, sb, sr;
    logic v;
    if (c.mov) begin
      exp_data = c.imm;
      exp_b    = 16'h0;
      exp_lat  = 1;
      m_r[c.rd] = c.imm;
      return;
    end
    a = m_r[c.rn];
    b = m_r[c.rm];
    case (c.sh)
      2'd1:    b = b << 1;
      2'd2:    b = b >> 1;
      2'd3:    b = $signed(b) >>> 1;
      default: ;
    endcase
    sa = $signed(a);
    sb = $signed(b);
    sr = 0;
    v  = 1'b0;
    case (c.op)
      2'd0:    begin sr = sa + sb; res = sr[15:0]; v = (sr > 32767) || (sr < -32768); end
      2'd1:    begin sr = sa - sb; res = sr[15:0]; v = (sr > 32767) || (sr < -32768); end
      2'd2:    res = a & b;
      default: res = ~b;
    endcase
    m_z = (res == 16'h0);
`ifdef SEQ_SIGNED_FLAGS_EN
    m_n = res[15];
    m_v = v;
`else
    m_n = 1'b0;
    m_v = 1'b0;
`endif
    if (c.wb) m_r[c.rd] = res;
    exp_data = res;
    exp_b    = b;
    exp_lat  = 4;
  endtask

  // Drives one command and measures accept-to-response latency; returns at the WB negedge.
  task automatic do_cmd(input cmd_t c, output int lat, output logic [15:0] data,
                        output logic [15:0] exec_b, output logic [1:0] exec_op);
    int n;
    lat = -1; data = 16'hxxxx; exec_b = 16'hxxxx; exec_op = 2'bxx;
    @(negedge clk);
    for (int w = 0; w < 20 && !cmd_ready; w++) @(negedge clk);
    cmd_mov = c.mov; cmd_op = c.op; cmd_wb = c.wb; cmd_rd = c.rd; cmd_rn = c.rn;
    cmd_rm = c.rm; cmd_shift = c.sh; cmd_imm = c.imm; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    while (n <= 20) begin
      if (n == 3) begin exec_b = alu_bin; exec_op = alu_op; end
      if (rsp_valid) begin lat = n; data = rsp_data; break; end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL reset_hs ready=%b valid=%b want 1/0", cmd_ready, rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if ({rsp_data, alu_ain, alu_bin, alu_op} !== 50'h0) $display("FAIL reset_out data=%h ain=%h bin=%h op=%b want 0", rsp_data, alu_ain, alu_bin, alu_op);
    else pass_cnt++;
    total_cnt++;
    if ({status_z, status_n, status_v} !== 3'b000) $display("FAIL reset_flags zn v=%b%b%b want 000", status_z, status_n, status_v);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      total_cnt++;
      if (dbg_data !== 16'h0) $display("FAIL reset_reg R%0d=%h want 0000", i, dbg_data);
      else pass_cnt++;
      m_r[i] = 16'h0;
    end
    m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
  endtask

  task automatic test_directed;
    cmd_t        tbl[$];
    logic [15:0] d_data[16], d_b[16];
    logic [1:0]  d_op[16];
    logic        d_z[16];
    logic [15:0] exp_data, exp_b, data, eb;
    logic [1:0]  eop;
    int          exp_lat, lat;
    tbl.push_back(mk(1, 2'd0, 0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0F80));
    tbl.push_back(mk(1, 2'd0, 0, 3'd1, 3'd0, 3'd0, 2'd0, 16'h0F00));
    tbl.push_back(mk(0, 2'd0, 1, 3'd2, 3'd0, 3'd1, 2'd0, 16'h0));
    tbl.push_back(mk(0, 2'd1, 0, 3'd7, 3'd0, 3'd0, 2'd0, 16'h0));
    tbl.push_back(mk(0, 2'd2, 1, 3'd3, 3'd0, 3'd1, 2'd1, 16'h0));
    tbl.push_back(mk(1, 2'd0, 0, 3'd4, 3'd0, 3'd0, 2'd0, 16'h8000));
    tbl.push_back(mk(0, 2'd3, 1, 3'd5, 3'd0, 3'd4, 2'd3, 16'h0));
    tbl.push_back(mk(1, 2'd0, 0, 3'd4, 3'd0, 3'd0, 2'd0, 16'h7FFF));
    tbl.push_back(mk(1, 2'd0, 0, 3'd5, 3'd0, 3'd0, 2'd0, 16'h0001));
    tbl.push_back(mk(0, 2'd0, 1, 3'd6, 3'd4, 3'd5, 2'd0, 16'h0));
    foreach (tbl[k]) begin
      model_cmd(tbl[k], exp_data, exp_b, exp_lat);
      do_cmd(tbl[k], lat, data, eb, eop);
      d_data[k] = data; d_b[k] = eb; d_op[k] = eop; d_z[k] = status_z;
      total_cnt++;
      if (lat !== exp_lat) $display("FAIL dir_latency cmd%0d got=%0d want=%0d", k, lat, exp_lat);
      else pass_cnt++;
      total_cnt++;
      if (data !== exp_data) $display("FAIL dir_rsp_data cmd%0d got=%h want=%h", k, data, exp_data);
      else pass_cnt++;
      total_cnt++;
      if ({status_z, status_n, status_v} !== {m_z, m_n, m_v}) $display("FAIL dir_flags cmd%0d znv=%b%b%b want %b%b%b", k, status_z, status_n, status_v, m_z, m_n, m_v);
      else pass_cnt++;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        dbg_sel = 3'(i);
        #1;
        total_cnt++;
        if (dbg_data !== m_r[i]) $display("FAIL dir_reg cmd%0d R%0d=%h want %h", k, i, dbg_data, m_r[i]);
        else pass_cnt++;
      end
    end
    // Hand-derived values for the key test-plan points
    total_cnt++;
    if (d_op[2] !== 2'b00) $display("FAIL add_exec_op got=%b want 00", d_op[2]);
    else pass_cnt++;
    total_cnt++;
    if (d_data[2] !== 16'h1E80) $display("FAIL add_result got=%h want 1E80", d_data[2]);
    else pass_cnt++;
    total_cnt++;
    if (d_data[3] !== 16'h0000 || d_z[3] !== 1'b1) $display("FAIL cmp_zero data=%h z=%b want 0000/1", d_data[3], d_z[3]);
    else pass_cnt++;
    total_cnt++;
    if (d_b[4] !== 16'h1E00 || d_data[4] !== 16'h0E00) $display("FAIL and_lsl b=%h res=%h want 1E00/0E00", d_b[4], d_data[4]);
    else pass_cnt++;
    total_cnt++;
    if (d_b[6] !== 16'hC000 || d_data[6] !== 16'h3FFF) $display("FAIL not_asr b=%h res=%h want C000/3FFF", d_b[6], d_data[6]);
    else pass_cnt++;
    dbg_sel = 3'd6;
    #1;
    total_cnt++;
    if (dbg_data !== 16'h8000) $display("FAIL add_ovf_result R6=%h want 8000", dbg_data);
    else pass_cnt++;
    total_cnt++;
`ifdef SEQ_SIGNED_FLAGS_EN
    if ({status_n, status_v} !== 2'b11) $display("FAIL add_ovf_nv got=%b%b want 11", status_n, status_v);
`else
    if ({status_n, status_v} !== 2'b00) $display("FAIL add_ovf_nv got=%b%b want 00", status_n, status_v);
`endif
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    cmd_t        c1, c2;
    logic [15:0] e1, e2, eb;
    int          l1, l2;
    c1 = mk(0, 2'd0, 1, 3'd7, 3'd2, 3'd3, 2'd0, 16'h0);
    c2 = mk(1, 2'd0, 0, 3'd6, 3'd0, 3'd0, 2'd0, 16'($urandom));
    model_cmd(c1, e1, eb, l1);
    model_cmd(c2, e2, eb, l2);
    @(negedge clk);
    cmd_mov = c1.mov; cmd_op = c1.op; cmd_wb = c1.wb; cmd_rd = c1.rd; cmd_rn = c1.rn;
    cmd_rm = c1.rm; cmd_shift = c1.sh; cmd_imm = c1.imm; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_mov = c2.mov; cmd_rd = c2.rd; cmd_imm = c2.imm; cmd_op = 2'd1; cmd_rn = 3'd5;
    for (int k = 1; k <= 4; k++) begin
      total_cnt++;
      if (cmd_ready !== 1'b0) $display("FAIL busy_ready cycle%0d got=%b want 0", k, cmd_ready);
      else pass_cnt++;
      if (k == 4) begin
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_data !== e1) $display("FAIL busy_first_rsp valid=%b data=%h want 1/%h", rsp_valid, rsp_data, e1);
        else pass_cnt++;
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL busy_idle ready=%b valid=%b want 1/0", cmd_ready, rsp_valid);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_data !== e2) $display("FAIL busy_second_rsp valid=%b data=%h want 1/%h", rsp_valid, rsp_data, e2);
    else pass_cnt++;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      total_cnt++;
      if (dbg_data !== m_r[i]) $display("FAIL busy_reg R%0d=%h want %h", i, dbg_data, m_r[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random;
    cmd_t        c;
    logic [15:0] exp_data, exp_b, data, eb;
    logic [1:0]  eop;
    int          exp_lat, lat;
    for (int k = 0; k < 40; k++) begin
      c = mk($urandom_range(0, 3) == 0, 2'($urandom), $urandom_range(0, 3) != 0,
             3'($urandom), 3'($urandom), 3'($urandom), 2'($urandom), 16'($urandom));
      model_cmd(c, exp_data, exp_b, exp_lat);
      do_cmd(c, lat, data, eb, eop);
      total_cnt++;
      if (lat !== exp_lat || data !== exp_data) $display("FAIL rand_rsp cmd%0d lat=%0d data=%h want %0d/%h", k, lat, data, exp_lat, exp_data);
      else pass_cnt++;
      if (!c.mov) begin
        total_cnt++;
        if (eb !== exp_b || eop !== c.op) $display("FAIL rand_exec cmd%0d bin=%h op=%b want %h/%b", k, eb, eop, exp_b, c.op);
        else pass_cnt++;
      end
      total_cnt++;
      if ({status_z, status_n, status_v} !== {m_z, m_n, m_v}) $display("FAIL rand_flags cmd%0d znv=%b%b%b want %b%b%b", k, status_z, status_n, status_v, m_z, m_n, m_v);
      else pass_cnt++;
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      total_cnt++;
      if (dbg_data !== m_r[i]) $display("FAIL rand_reg R%0d=%h want %h", i, dbg_data, m_r[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid;
    logic saw_rsp;
    @(negedge clk);
    cmd_mov = 1'b0; cmd_op = 2'd0; cmd_wb = 1'b1; cmd_rd = 3'd2; cmd_rn = 3'd0;
    cmd_rm = 3'd1; cmd_shift = 2'd0; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    reset = 1'b1;
    #1;
    total_cnt++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 16'h0) $display("FAIL midrst_hs ready=%b valid=%b data=%h want 1/0/0000", cmd_ready, rsp_valid, rsp_data);
    else pass_cnt++;
    total_cnt++;
    if ({status_z, status_n, status_v, alu_op} !== 5'b0) $display("FAIL midrst_flags znv=%b%b%b op=%b want 0", status_z, status_n, status_v, alu_op);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      total_cnt++;
      if (dbg_data !== 16'h0) $display("FAIL midrst_reg R%0d=%h want 0000", i, dbg_data);
      else pass_cnt++;
      m_r[i] = 16'h0;
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    saw_rsp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
    end
    total_cnt++;
    if (saw_rsp !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL midrst_after rsp_seen=%b ready=%b want 0/1", saw_rsp, cmd_ready);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_mov = 1'b0; cmd_op = 2'd0; cmd_wb = 1'b0;
    cmd_rd = 3'd0; cmd_rn = 3'd0; cmd_rm = 3'd0; cmd_shift = 2'd0; cmd_imm = 16'h0;
    dbg_sel = 3'd0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Multi-cycle datapath controller that drives the existing 16-bit ALU (Ain, Bin, 2-bit ALUop, out, Z). It accepts ALU and MOV-immediate commands over a valid/ready handshake and reads operands from an internal 8x16 register file. It shifts Bin, issues the operation to the ALU, captures the result and Z flag, and writes back. It sits between the instruction decoder and the ALU.

Parameters:
DATA_W, 16, datapath width; matches the ALU.
NREGS, 8, register file depth; register select width is log2(NREGS) = 3.

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high; clears all state
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept; equals (state==IDLE)
cmd_mov  in  1  1 = write cmd_imm to Rd; the ALU is not used
cmd_op  in  2  ALUop: 00 ADD, 01 SUB, 10 AND, 11 NOT(Bin)
cmd_wb  in  1  1 = write result to Rd; 0 = flags only (compare)
cmd_rd  in  3  destination register
cmd_rn  in  3  A-operand register
cmd_rm  in  3  B-operand register
cmd_shift  in  2  B shift: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
cmd_imm  in  16  MOV immediate
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  16  result of the completed command; held until the next completion
status_z  out  1  registered Z from the last non-MOV command
status_n  out  1  negative flag (see Optional Feature)
status_v  out  1  overflow flag (see Optional Feature)
alu_ain  out  16  to ALU Ain
alu_bin  out  16  to ALU Bin
alu_op  out  2  to ALU ALUop
alu_out  in  16  from ALU out
alu_z  in  1  from ALU Z
dbg_sel  in  3  debug read select
dbg_data  out  16  combinational R[dbg_sel]

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; R0..R7=0; A, B, C=0; status_z/n/v=0.
  - rsp_valid=0, rsp_data=0; alu_ain=alu_bin=0, alu_op=00.
  - cmd_ready=1 once reset deasserts.
- States: IDLE, RDA, RDB, EXEC, WB.
- IDLE: on cmd_valid&cmd_ready, latch all cmd fields.
  - cmd_mov=1 -> WB.
  - cmd_mov=0 -> RDA.
- RDA: A <= R[rn].
- RDB: B <= shift(R[rm]).
  - LSL1: {b[14:0],0}.
  - LSR1: {0,b[15:1]}.
  - ASR1: {b[15],b[15:1]}.
- EXEC: alu_ain=A, alu_bin=B, alu_op=op (driven from registers, stable the whole cycle).
  - C <= alu_out; status_z <= alu_z.
  - For NOT, A is still driven; the ALU ignores it.
- WB:
  - Write R[rd] <= (mov ? imm : C) if (mov | wb).
  - rsp_valid=1 for this cycle only; rsp_data <= written or computed value.
  - Next state IDLE.
- Latency: accept at edge T.
  - ALU command: rsp_valid high in cycle T+4; next accept possible at T+5.
  - MOV: rsp_valid high at T+1.
- Busy: cmd_ready=0 outside IDLE; cmd_valid is ignored and no fields are latched.
- Operand hazards: none. Rd may equal Rn/Rm, since reads complete before WB.
- Flags: MOV does not alter status_*. Compare (wb=0) updates flags, leaves the register file unchanged, and still pulses rsp_valid with C on rsp_data.
- Arithmetic: modulo 2^16; carry-out is discarded.
- Reset mid-operation: the command is aborted, there is no writeback, and no rsp_valid pulse.

Optional Feature:
SEQ_SIGNED_FLAGS_EN
- Defined: in EXEC, status_n <= alu_out[15].
  - status_v for ADD: (A[15]==B[15]) & (alu_out[15]!=A[15]).
  - status_v for SUB: (A[15]!=B[15]) & (alu_out[15]!=A[15]).
  - status_v for AND/NOT: 0.
- Undefined: status_n and status_v are tied to 0. The ports are present in both builds.

Decomposition:
- Package alu_seq_pkg:
  - DATA_W, REG_SEL_W constants.
  - alu_op_e (ADD/SUB/AND/NOT), shift_e (NONE/LSL1/LSR1/ASR1), seq_state_e.
  - Flag-computation function.
- Sub-module bin_shifter: combinational 16-bit shift by shift_e. Instantiated once in the RDB path.

Test Plan:
- Reset, MOV R0<-0x0F80, MOV R1<-0x0F00 -> rsp_valid 1 cycle after each accept; dbg_data R0=0x0F80, R1=0x0F00; status_z=0.
- ADD R2=R0+R1, shift none -> rsp_valid 4 cycles after accept; R2=0x1E80; status_z=0; alu_op=00 during EXEC.
- SUB wb=0 R0-R0 -> status_z=1; rsp_data=0x0000; R0..R7 unchanged. With SEQ_SIGNED_FLAGS_EN, MOV R4<-0x7FFF, R5<-0x0001; ADD R6=R4+R5 -> R6=0x8000, status_n=1, status_v=1.
- AND R3=R0&(R1 LSL1) -> B=0x1E00, R3=0x0E00. MOV R4<-0x8000; NOT R5=~(R4 ASR1) -> B=0xC000, R5=0x3FFF.
- cmd_valid held high through a busy command with different fields -> cmd_ready=0 in RDA..WB; only the first command executes; the second is accepted in the next IDLE.
- Assert reset during EXEC of ADD R2 -> state IDLE immediately; all registers 0; no rsp_valid; cmd_ready=1 after release.
